mac_dot_seq: RTL and testbench

//  Sequencer that runs a dot product of LEN operand pairs through the team's 8x8 MAC datapath (registered multiply + accumulate).

---
 rtl/mac_dot_seq_if.sv | 29 ++
 rtl/mac_dot_seq.sv | 141 ++++++++++++++
 tb/tb_mac_dot_seq.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_dot_seq_if.sv
// Job, operand-stream and result handshake bundle for the dot-product sequencer.
// The feeder/consumer side takes the master modport and the sequencer takes the slave modport.
interface mac_dot_seq_if #(
  parameter int DW = 8,
  parameter int CW = 5,
  parameter int AW = 20
);
  logic          start;
  logic [CW-1:0] len;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] X;
  logic [DW-1:0] Y;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] acc_out;
  logic          ovf;

  modport master (
    output start, len, in_valid, X, Y, out_ready,
    input  in_ready, busy, out_valid, acc_out, ovf
  );

  modport slave (
    input  start, len, in_valid, X, Y, out_ready,
    output in_ready, busy, out_valid, acc_out, ovf
  );
endinterface

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams len X/Y pairs through a registered multiply and an accumulator,
// then holds the sum on a valid/ready result port until the consumer takes it.
module mac_dot_seq #(
  parameter int DW    = 8,
  parameter int CW    = 5,
  parameter int N_MAX = 16,
  parameter int AW    = 20
) (
  input  logic          clk,
  input  logic          reset,
  mac_dot_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] N_MAX_C = CW'(N_MAX);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t          state_r;
  logic [CW-1:0]   n_r;
  logic [CW-1:0]   count_r;
  logic [2*DW-1:0] prod_r;
  logic            prod_vld_r;
  logic [AW-1:0]   acc_r;
  logic [AW-1:0]   acc_out_r;
  logic            ovf_r;
  logic            in_ready_r;
  logic            busy_r;
  logic            out_valid_r;

  logic [AW:0]     sum_s;
  logic [CW-1:0]   len_clamped_s;
  logic            accept_s;

  // Accumulator adder with carry, length clamp and beat-accept decode.
  always_comb begin
    sum_s         = {1'b0, acc_r} + (AW+1)'(prod_r);
    len_clamped_s = (bus.len > N_MAX_C) ? N_MAX_C : bus.len;
    accept_s      = bus.in_valid & in_ready_r;
  end

  // Sequencer FSM with multiply/accumulate pipeline and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      n_r         <= {CW{1'b0}};
      count_r     <= {CW{1'b0}};
      prod_r      <= {(2*DW){1'b0}};
      prod_vld_r  <= 1'b0;
      acc_r       <= {AW{1'b0}};
      acc_out_r   <= {AW{1'b0}};
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      // The last product lands one edge after its beat, while count already equals n.
      if ((state_r != IDLE) && prod_vld_r) begin
        acc_r <= sum_s[AW-1:0];
        if (sum_s[AW]) begin
          ovf_r <= 1'b1;
        end
      end

      case (state_r)
        IDLE: begin
          prod_vld_r <= 1'b0;
          if (bus.start) begin
            acc_r   <= {AW{1'b0}};
            ovf_r   <= 1'b0;
            count_r <= {CW{1'b0}};
            busy_r  <= 1'b1;
            if (bus.len != {CW{1'b0}}) begin
              n_r        <= len_clamped_s;
              in_ready_r <= 1'b1;
              state_r    <= RUN;
            end else begin
              acc_out_r   <= {AW{1'b0}};
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end
          end
        end

        RUN: begin
          if (count_r == n_r) begin
            prod_vld_r <= 1'b0;
            state_r    <= DRAIN;
          end else if (accept_s) begin
            prod_r     <= {{DW{1'b0}}, bus.X} * {{DW{1'b0}}, bus.Y};
            prod_vld_r <= 1'b1;
            count_r    <= count_r + ONE_C;
            if (count_r == (n_r - ONE_C)) begin
              in_ready_r <= 1'b0;
            end
          end else begin
            prod_vld_r <= 1'b0;
          end
        end

        DRAIN: begin
          prod_vld_r  <= 1'b0;
          acc_out_r   <= acc_r;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end

        DONE: begin
          prod_vld_r <= 1'b0;
          if (out_valid_r && bus.out_ready) begin
            acc_out_r   <= {AW{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end

        default: begin
          prod_vld_r  <= 1'b0;
          in_ready_r  <= 1'b0;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
          acc_out_r   <= {AW{1'b0}};
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;
  assign bus.acc_out   = acc_out_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Scoreboard bench: two sequencers (AW=20 and AW=16) share one directed stimulus stream;
// jobs push hand-computed results, per-DUT monitors pop and compare on each result handshake.
module tb_mac_dot_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] len;
  logic       in_valid;
  logic [7:0] x;
  logic [7:0] y;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_a_q[$];
  logic        exp_ova_q[$];
  logic [15:0] exp_b_q[$];
  logic        exp_ovb_q[$];

  always #5 clk = ~clk;

  mac_dot_seq_if #(.DW(8), .CW(5), .AW(20)) if_a();
  mac_dot_seq_if #(.DW(8), .CW(5), .AW(16)) if_b();

  assign if_a.start     = start;
  assign if_a.len       = len;
  assign if_a.in_valid  = in_valid;
  assign if_a.X         = x;
  assign if_a.Y         = y;
  assign if_a.out_ready = out_ready;
  assign if_b.start     = start;
  assign if_b.len       = len;
  assign if_b.in_valid  = in_valid;
  assign if_b.X         = x;
  assign if_b.Y         = y;
  assign if_b.out_ready = out_ready;

  mac_dot_seq #(.DW(8), .CW(5), .N_MAX(16), .AW(20)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave)
  );
  mac_dot_seq #(.DW(8), .CW(5), .N_MAX(16), .AW(16)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Result monitors: one pop-and-compare per completed result handshake.
  always @(negedge clk) begin
    if (reset === 1'b1 && if_a.out_valid === 1'b1 && out_ready === 1'b1) begin
      check("a_result_expected", exp_a_q.size(), 1);
      if (exp_a_q.size() > 0) begin
        check("a_acc_out", if_a.acc_out, exp_a_q.pop_front());
        check("a_ovf", if_a.ovf, exp_ova_q.pop_front());
      end
    end
    if (reset === 1'b1 && if_b.out_valid === 1'b1 && out_ready === 1'b1) begin
      check("b_result_expected", exp_b_q.size(), 1);
      if (exp_b_q.size() > 0) begin
        check("b_acc_out", if_b.acc_out, exp_b_q.pop_front());
        check("b_ovf", if_b.ovf, exp_ovb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [4:0] l, input bit push,
                           input logic [19:0] ea, input logic oa,
                           input logic [15:0] eb, input logic ob);
    if (push) begin
      exp_a_q.push_back(ea);
      exp_ova_q.push_back(oa);
      exp_b_q.push_back(eb);
      exp_ovb_q.push_back(ob);
    end
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] xv, input logic [7:0] yv);
    int  n  = 0;
    bit  ok = 1'b0;
    x        = xv;
    y        = yv;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = (if_a.in_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 20);
    in_valid = 1'b0;
    check("beat_accepted", ok, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (if_a.busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, if_a.busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with random inputs
    reset     = 1'b0;
    start     = 1'($urandom);
    len       = 5'($urandom);
    in_valid  = 1'($urandom);
    x         = 8'($urandom);
    y         = 8'($urandom);
    out_ready = 1'($urandom);
    tick();
    tick();
    check("rst_in_ready", if_a.in_ready, 0);
    check("rst_busy", if_a.busy, 0);
    check("rst_out_valid", if_a.out_valid, 0);
    check("rst_ovf", if_a.ovf, 0);
    check("rst_acc_out", if_a.acc_out, 0);
    check("rst_b_busy", if_b.busy, 0);
    start     = 1'b0;
    len       = 5'd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    tick();

    // 2: back-to-back beats, result two edges after the last accept
    start_job(5'd3, 1'b1, 20'd3690, 1'b0, 16'd3690, 1'b0);
    beat(8'd69, 8'd47);
    beat(8'd16, 8'd19);
    beat(8'd13, 8'd11);
    @(negedge clk);
    check("lat_after_k", if_a.out_valid, 0);
    @(negedge clk);
    check("lat_after_k1", if_a.out_valid, 0);
    @(negedge clk);
    check("lat_after_k2", if_a.out_valid, 1);
    @(posedge clk);
    #1;
    wait_idle("idle_after_t2");

    // 3: two-cycle bubbles between beats
    start_job(5'd3, 1'b1, 20'd3690, 1'b0, 16'd3690, 1'b0);
    beat(8'd69, 8'd47);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bubble_in_ready", if_a.in_ready, 1);
      tick();
    end
    beat(8'd16, 8'd19);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bubble_in_ready", if_a.in_ready, 1);
      tick();
    end
    beat(8'd13, 8'd11);
    wait_idle("idle_after_t3");

    // 4: zero-length job, then clamped 20 -> 16 full-scale beats
    start_job(5'd0, 1'b1, 20'd0, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    check("len0_valid_next", if_a.out_valid, 1);
    @(posedge clk);
    #1;
    wait_idle("idle_after_len0");
    start_job(5'd20, 1'b1, 20'd1040400, 1'b0, 16'd57360, 1'b1);
    for (int i = 0; i < 16; i++) beat(8'd255, 8'd255);
    in_valid = 1'b1;
    @(negedge clk);
    check("beat17_refused", if_a.in_ready, 0);
    tick();
    in_valid = 1'b0;
    wait_idle("idle_after_clamp");

    // 5: consumer stalls in DONE while start is pulsed
    out_ready = 1'b0;
    start_job(5'd3, 1'b1, 20'd3690, 1'b0, 16'd3690, 1'b0);
    beat(8'd69, 8'd47);
    beat(8'd16, 8'd19);
    beat(8'd13, 8'd11);
    begin
      int n = 0;
      @(negedge clk);
      while (if_a.out_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("stall_valid_seen", if_a.out_valid, 1);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      len   = 5'd1;
      @(negedge clk);
      check("stall_acc_hold", if_a.acc_out, 20'd3690);
      check("stall_valid_hold", if_a.out_valid, 1);
      tick();
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("start_not_queued", if_a.busy, 0);
    @(posedge clk);
    #1;

    // 5b: reset mid-job discards it
    start_job(5'd4, 1'b0, 20'd0, 1'b0, 16'd0, 1'b0);
    beat(8'd10, 8'd10);
    beat(8'd20, 8'd20);
    reset = 1'b0;
    tick();
    check("midrst_in_ready", if_a.in_ready, 0);
    check("midrst_busy", if_a.busy, 0);
    check("midrst_out_valid", if_a.out_valid, 0);
    reset = 1'b1;
    tick();
    start_job(5'd1, 1'b1, 20'd12, 1'b0, 16'd12, 1'b0);
    beat(8'd3, 8'd4);
    wait_idle("idle_after_midrst");

    // 6: overflow on the narrow accumulator, then cleared by the next job
    start_job(5'd2, 1'b1, 20'd130050, 1'b0, 16'd64514, 1'b1);
    beat(8'd255, 8'd255);
    beat(8'd255, 8'd255);
    wait_idle("idle_after_ovf");
    start_job(5'd1, 1'b1, 20'd1, 1'b0, 16'd1, 1'b0);
    beat(8'd1, 8'd1);
    wait_idle("idle_after_final");

    check("a_queue_drained", exp_a_q.size(), 0);
    check("b_queue_drained", exp_b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
